// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and GF(2^8) helpers.
// Used by key_schedule and subword.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic {
    IDLE,
    EMIT
  } ks_state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8 * (255 - int'(b)) +: 8];
  endfunction

endpackage

// File: rtl/key_round.sv
// One combinational AES-128 key expansion step: current key + rcon -> next key.
module key_round (
  input  logic [127:0] key_cur,
  input  logic [7:0]   rcon,
  output logic [127:0] key_nxt
);

  // w[0..3] are the current words (w[0] = key_cur[127:96]), w[4..7] the new ones.
  logic [7:0][31:0] w;
  logic [31:0]      sub;
  logic [31:0]      t;

  subword u_subword (
    .din  ({w[3][23:0], w[3][31:24]}),
    .dout (sub)
  );

  assign t = sub ^ {rcon, 24'h0};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cur
      assign w[gi] = key_cur[127 - 32*gi -: 32];
    end
    for (genvar gi = 4; gi < 8; gi++) begin : g_nxt
      if (gi == 4) begin : g_first
        assign w[gi] = w[0] ^ t;
      end else begin : g_chain
        assign w[gi] = w[gi-4] ^ w[gi-1];
      end
      assign key_nxt[127 - 32*(gi-4) -: 32] = w[gi];
    end
  endgenerate

endmodule

// File: rtl/subword.sv
// Byte-wise S-box substitution of a 32-bit word (AES SubWord).
module subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
    end
  endgenerate

endmodule

// File: rtl/key_schedule.sv
// Sequential AES-128 key expansion: emits round keys 0..NR over a valid/ready handshake.
// Optional round-key store for reverse replay is enabled by defining KEY_SCHEDULE_STORE_EN.
module key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] roundkey,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_t    state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   round_reg, round_next;
  logic [7:0]   rcon_reg, rcon_next;
  logic         done_reg, done_next;
  logic [127:0] expanded;

  key_round u_key_round (
    .key_cur (key_reg),
    .rcon    (rcon_reg),
    .key_nxt (expanded)
  );

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next   = key;
          round_next = 4'd0;
          rcon_next  = RCON_INIT;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_reg == LAST_ROUND) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            key_next   = expanded;
            round_next = round_reg + 4'd1;
            rcon_next  = xtime(rcon_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      round_reg <= '0;
      rcon_reg  <= RCON_INIT;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
      done_reg  <= done_next;
    end
  end

  assign rk_valid = (state_reg == EMIT);
  assign roundkey = rk_valid ? key_reg : '0;
  assign round    = rk_valid ? round_reg : 4'd0;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

`ifdef KEY_SCHEDULE_STORE_EN
  logic [127:0] store_mem [0:NR];
  logic [NR:0]  store_valid_reg;
  logic [127:0] rd_data_reg;

  // Array kept reset-free so it maps to RAM; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (state_reg == EMIT) begin
      store_mem[round_reg] <= key_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_valid_reg <= '0;
      rd_data_reg     <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        store_valid_reg <= '0;
      end else if (state_reg == EMIT) begin
        store_valid_reg[round_reg] <= 1'b1;
      end
      if (rd_idx <= LAST_ROUND && store_valid_reg[rd_idx]) begin
        rd_data_reg <= store_mem[rd_idx];
      end else begin
        rd_data_reg <= '0;
      end
    end
  end

  assign rd_data = rd_data_reg;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: FIPS-197 vectors, stalls, restart, reset, store reads.
module tb_key_schedule;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef KEY_SCHEDULE_STORE_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, rk_ready;
  logic [127:0] key;
  logic         rk_valid, busy, done;
  logic [127:0] roundkey, rd_data;
  logic [3:0]   round, rd_idx;

  key_schedule #(.NR(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .roundkey (roundkey),
    .round    (round),
    .busy     (busy),
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] rk;
  } vec_t;

  vec_t         vecs [17];
  logic [127:0] got [11];
  int           n_total = 0;
  int           n_pass  = 0;
  int           done_cycles;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cmp_table(input logic [127:0] k, input string tag);
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].key == k) begin
        chk($sformatf("%s_round%0d", tag, vecs[i].rnd), got[vecs[i].rnd], vecs[i].rk);
        $display("%s round %0d: %h", tag, vecs[i].rnd, got[vecs[i].rnd]);
      end
    end
  endtask

  // Starts an expansion at the current negedge and consumes all 11 keys; returns in the done cycle.
  task automatic expand(input logic [127:0] k, input bit stall, input bit poke);
    int           idx;
    int           cyc;
    bit           hold;
    logic [127:0] prev_rk;
    logic [3:0]   prev_rd;
    for (int i = 0; i < 11; i++) got[i] = '0;
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    cyc   = 1;
    idx   = 0;
    hold  = 1'b0;
    while (idx < 11 && cyc < 300) begin
      chk("valid_in_emit", {127'b0, rk_valid}, 128'd1);
      chk("done_early", {127'b0, done}, 128'd0);
      if (hold) begin
        chk("stall_roundkey", roundkey, prev_rk);
        chk("stall_round", {124'b0, round}, {124'b0, prev_rd});
      end
      start = 1'b0;
      if (poke && idx == 3) begin
        start = 1'b1;
        key   = ~k;
      end
      rk_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      hold     = !rk_ready;
      prev_rk  = roundkey;
      prev_rd  = round;
      if (rk_valid && rk_ready) begin
        chk("round_seq", {124'b0, round}, 128'(idx));
        got[idx] = roundkey;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    chk("all_rounds_seen", 128'(idx), 128'd11);
    chk("done_pulse", {127'b0, done}, 128'd1);
    chk("busy_in_done", {127'b0, busy}, 128'd0);
    chk("valid_in_done", {127'b0, rk_valid}, 128'd0);
    done_cycles = cyc;
  endtask

  task automatic rd_check(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rd_idx = idx;
    @(negedge clk);
    chk(name, rd_data, exp);
    $display("read idx %0d: %h", idx, rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    vecs[0]  = '{K_FIPS, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{K_FIPS, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{K_FIPS, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{K_FIPS, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{K_FIPS, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{K_FIPS, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{K_FIPS, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{K_FIPS, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{K_FIPS, 8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{K_FIPS, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{K_FIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[11] = '{K_ZERO, 0,  128'h0};
    vecs[12] = '{K_ZERO, 1,  128'h62636363626363636263636362636363};
    vecs[13] = '{K_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[14] = '{K_SEQ,  0,  K_SEQ};
    vecs[15] = '{K_SEQ,  1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[16] = '{K_SEQ,  10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

    reset = 1'b1; start = 1'b0; rk_ready = 1'b0; key = '0; rd_idx = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {127'b0, rk_valid}, 128'd0);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_done", {127'b0, done}, 128'd0);
    chk("reset_roundkey", roundkey, 128'd0);
    chk("reset_round", {124'b0, round}, 128'd0);
    chk("reset_rd_data", rd_data, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 key, consumer always ready.
    expand(K_FIPS, 1'b0, 1'b0);
    chk("done_latency", 128'(done_cycles), 128'd12);
    cmp_table(K_FIPS, "fips");
    rd_check(4'd10, STORE ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 : 128'h0, "store_rd10");
    rd_check(4'd12, 128'h0, "store_rd12");
    rd_check(4'd0, STORE ? K_FIPS : 128'h0, "store_rd0");

    // Same key with random stalls, then restart in the done cycle.
    expand(K_FIPS, 1'b1, 1'b0);
    cmp_table(K_FIPS, "fips_stall");
    start = 1'b1;
    key   = K_SEQ;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", {127'b0, rk_valid}, 128'd1);
    chk("restart_round", {124'b0, round}, 128'd0);
    chk("restart_roundkey", roundkey, K_SEQ);
    $display("restart in done cycle: round %0d %h", round, roundkey);
    rk_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("restart_drain_done", {127'b0, done}, 128'd1);
    rk_ready = 1'b0;

    // All-zero key with a start pulse while busy.
    expand(K_ZERO, 1'b0, 1'b1);
    cmp_table(K_ZERO, "zero");

    // Reset during round 5, together with a start that must lose.
    start = 1'b1; key = K_FIPS;
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b1;
    cyc = 0;
    while (!(rk_valid && round == 4'd5) && cyc < 50) begin @(negedge clk); cyc++; end
    chk("reached_round5", {124'b0, round}, 128'd5);
    reset = 1'b1; start = 1'b1; key = K_SEQ;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; rk_ready = 1'b0;
    chk("midreset_valid", {127'b0, rk_valid}, 128'd0);
    chk("midreset_busy", {127'b0, busy}, 128'd0);
    chk("midreset_roundkey", roundkey, 128'd0);
    chk("midreset_round", {124'b0, round}, 128'd0);
    $display("reset at round 5: valid %0b busy %0b", rk_valid, busy);
    rd_check(4'd10, 128'h0, "midreset_store_cleared");

    // Fresh start after reset uses the new key from round 0.
    expand(K_SEQ, 1'b1, 1'b0);
    cmp_table(K_SEQ, "seq");
    rd_check(4'd1, STORE ? 128'hd6aa74fdd2af72fadaa678f1d6ab76fe : 128'h0, "store_rd1_seq");
    rd_check(4'd15, 128'h0, "store_rd15");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
